// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS BCD digits onto one shared 7-segment decoder, committing
// double-buffered data only at frame wrap. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  output logic [3:0]                    digit,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done,
  output logic                          pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] pend_buf;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              digit_sel;
  logic                    slot_blank;
  logic [NUM_DIGITS-1:0]   anode_next;

  assign tick      = enable && (cnt == CNT_MAX);
  assign wrap      = tick && (idx == IDX_MAX);
  assign digit_idx = idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    digit_sel = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) digit_sel = display[4*k +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A slot is dark when it and every more-significant digit are zero; slot 0 always lights.
  logic [NUM_DIGITS-1:0] blank;
  logic                  upper_zero;

  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (display[4*k +: 4] == 4'h0);
      blank[k]   = upper_zero;
    end
  end

  always_comb begin
    slot_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) slot_blank = blank[k];
    end
  end
`else
  assign slot_blank = 1'b0;
`endif

  always_comb begin
    anode_next = '1;
    if (enable && !slot_blank) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IDX_W'(k)) anode_next[k] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the digit buffers are plain registers, so they are reset with everything else.
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      pend_buf   <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      digit      <= 4'h0;
      anode_n    <= '1;
    end else begin
      if (enable) begin
        cnt <= tick ? '0 : cnt + CNT_W'(1);
        if (tick) idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      frame_done <= wrap;

      if (wrap && pending) begin
        display <= pend_buf;
        pending <= 1'b0;
      end
      // A load on the wrap edge comes later, so it re-arms pending after the commit.
      if (load) begin
        pend_buf <= digits_in;
        pending  <= 1'b1;
      end

      digit   <= digit_sel;
      anode_n <= anode_next;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: an elapsed-time model checked every cycle,
// plus directed literal checks. Define LEADING_ZERO_BLANK_EN to match the RTL build.
module tb_display_scan_controller;

  localparam int N  = 4;
  localparam int TD = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          load = 1'b0;
  logic [4*N-1:0] digits_in = '0;

  logic [3:0]    digit;
  logic [N-1:0]  anode_n;
  logic [1:0]    digit_idx;
  logic          frame_done;
  logic          pending;

  logic [3:0]    f_digit;
  logic [N-1:0]  f_anode_n;
  logic [1:0]    f_digit_idx;
  logic          f_frame_done;
  logic          f_pending;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  display_scan_controller #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .digit(digit), .anode_n(anode_n), .digit_idx(digit_idx),
    .frame_done(frame_done), .pending(pending)
  );

  display_scan_controller #(.NUM_DIGITS(N), .TICK_DIV(1)) dut_fast (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .digit(f_digit), .anode_n(f_anode_n), .digit_idx(f_digit_idx),
    .frame_done(f_frame_done), .pending(f_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position in the scan follows from the number of enabled cycles since reset.
  int unsigned   t = 0;
  logic [4*N-1:0] m_disp = '0;
  logic [4*N-1:0] m_pbuf = '0;
  bit            m_pend = 1'b0;
  logic [3:0]    exp_digit = 4'h0;
  logic [N-1:0]  exp_anode = '1;
  bit            exp_fd = 1'b0;
  int            exp_idx = 0;

  function automatic bit blanked(int k, logic [4*N-1:0] d);
    return LZB && (k > 0) && ((d >> (4*k)) == 0);
  endfunction

  always @(posedge clk) begin
    int  slot;
    bit  wrap;
    if (rst) begin
      t = 0; m_disp = '0; m_pbuf = '0; m_pend = 1'b0;
      exp_digit = 4'h0; exp_anode = '1; exp_fd = 1'b0;
    end else begin
      slot      = (t / TD) % N;
      exp_digit = m_disp[4*slot +: 4];
      exp_anode = (enable && !blanked(slot, m_disp)) ? ~(N'(1) << slot) : '1;
      wrap      = enable && (((t + 1) % (TD * N)) == 0);
      exp_fd    = wrap;
      if (enable) t++;
      if (wrap && m_pend) begin
        m_disp = m_pbuf;
        m_pend = 1'b0;
      end
      if (load) begin
        m_pbuf = digits_in;
        m_pend = 1'b1;
      end
    end
    exp_idx = (t / TD) % N;
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("m_digit", digit, exp_digit);
      check("m_anode_n", anode_n, exp_anode);
      check("m_frame_done", frame_done, exp_fd);
      check("m_pending", pending, m_pend);
      check("m_digit_idx", digit_idx, exp_idx);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] v);
    load = 1'b1;
    digits_in = v;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    tick(1);
    cmp_on = 1'b1;
    tick(1);
    check("rst_anode_n", anode_n, 4'b1111);
    check("rst_digit", digit, 4'h0);
    rst = 1'b0;

    // Scan order after reset release
    tick(1);  check("scan_s0", anode_n, 4'b1110);
    tick(4);  check("scan_s1", anode_n, 4'b1101);
    tick(4);  check("scan_s2", anode_n, 4'b1011);
    tick(4);  check("scan_s3", anode_n, 4'b0111);
    tick(3);  check("frame_done_pulse", frame_done, 1'b1);
    tick(1);  check("scan_wrap", anode_n, 4'b1110);
              check("frame_done_low", frame_done, 1'b0);

    // Load mid-frame, commit at wrap
    tick(3);
    do_load(16'h1234);
    check("load_pending", pending, 1'b1);
    check("load_no_early_show", digit, 4'h0);
    tick(12); check("commit_d0", digit, 4'h4);
              check("commit_pending_clr", pending, 1'b0);
    tick(4);  check("commit_d1", digit, 4'h3);
    tick(4);  check("commit_d2", digit, 4'h2);
    tick(4);  check("commit_d3", digit, 4'h1);

    // Last load wins; load on the wrap edge defers to the next frame
    tick(4);
    do_load(16'h1111);
    do_load(16'h5678);
    tick(12);
    do_load(16'h9999);
    check("wrap_load_pending", pending, 1'b1);
    tick(1);  check("lastwins_d0", digit, 4'h8);
    tick(4);  check("lastwins_d1", digit, 4'h7);
    tick(4);  check("lastwins_d2", digit, 4'h6);
    tick(4);  check("lastwins_d3", digit, 4'h5);
    tick(4);  check("deferred_d0", digit, 4'h9);
              check("deferred_pending_clr", pending, 1'b0);

    // Freeze in slot 2 with one prescaler count already spent
    tick(8);
    enable = 1'b0;
    tick(1);  check("frz_blank", anode_n, 4'b1111);
              check("frz_idx", digit_idx, 2'd2);
    tick(9);  check("frz_blank_end", anode_n, 4'b1111);
              check("frz_idx_end", digit_idx, 2'd2);
    enable = 1'b1;
    tick(1);  check("resume_s2", anode_n, 4'b1011);
    tick(1);  check("resume_idx", digit_idx, 2'd2);
    tick(1);  check("resume_adv_idx", digit_idx, 2'd3);
    tick(1);  check("resume_s3", anode_n, 4'b0111);

    // Reset mid-frame drops the pending value
    do_load(16'h4321);
    check("pre_rst_pending", pending, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);  check("mid_rst_digit", digit, 4'h0);
              check("mid_rst_anode_n", anode_n, 4'b1111);
              check("mid_rst_pending", pending, 1'b0);
              check("mid_rst_idx", digit_idx, 2'd0);
    tick(1);
    rst = 1'b0;

    // Restart at slot 0; TICK_DIV=1 instance advances every cycle
    tick(1);  check("restart_s0", anode_n, 4'b1110);
              check("restart_digit", digit, 4'h0);
              check("fast_s0", f_anode_n, 4'b1110);
    tick(1);  check("fast_s1", f_anode_n, 4'b1101);
    tick(1);  check("fast_s2", f_anode_n, 4'b1011);
    tick(1);  check("fast_s3", f_anode_n, 4'b0111);
              check("fast_frame_done", f_frame_done, 1'b1);

    // Leading-zero behaviour (blanked only in the LEADING_ZERO_BLANK_EN build)
    do_load(16'h0042);
    tick(12); check("lz42_s0", anode_n, 4'b1110);
              check("lz42_d0", digit, 4'h2);
    tick(4);  check("lz42_s1", anode_n, 4'b1101);
              check("lz42_d1", digit, 4'h4);
    tick(4);  check("lz42_s2", anode_n, LZB ? 4'b1111 : 4'b1011);
              check("lz42_d2", digit, 4'h0);
    tick(4);  check("lz42_s3", anode_n, LZB ? 4'b1111 : 4'b0111);
    do_load(16'h0000);
    tick(3);  check("lz0_s0", anode_n, 4'b1110);
              check("lz0_d0", digit, 4'h0);
    tick(4);  check("lz0_s1", anode_n, LZB ? 4'b1111 : 4'b1101);
    do_load(16'h1000);
    tick(11); check("lz1000_s0", anode_n, 4'b1110);
    tick(4);  check("lz1000_s1", anode_n, 4'b1101);
    tick(8);  check("lz1000_s3", anode_n, 4'b0111);
              check("lz1000_d3", digit, 4'h1);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
